// File: rtl/fx_bus_arb_pkg.sv
// Shared widths, address field positions, state encoding and latencies for the fx bus arbiter.
// Optional lock support is enabled with FX_BUS_ARB_LOCK_EN.
package fx_bus_pkg;
  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 8;
  localparam int DEV_ID_MSB = 21;
  localparam int DEV_ID_LSB = 16;

  // Cycles from the IDLE cycle that samples req to the ack pulse.
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;
endpackage

// File: rtl/fx_bus_arb_if.sv
// Master request ports and slave-side fx bus of the arbiter, bundled as one interface.
// FX_BUS_ARB_LOCK_EN adds the per-master lock inputs.
interface fx_bus_arb_if;
  import fx_bus_pkg::*;

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_q;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_q;

`ifdef FX_BUS_ARB_LOCK_EN
  logic              m0_lock;
  logic              m1_lock;
`endif

  logic              fx_wr;
  logic [ADDR_W-1:0] fx_waddr;
  logic [DATA_W-1:0] fx_data;
  logic              fx_rd;
  logic [ADDR_W-1:0] fx_raddr;
  logic [DATA_W-1:0] fx_q;
  logic              busy;

  // Arbiter view.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
`ifdef FX_BUS_ARB_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    input  fx_q,
    output m0_ack, m0_q, m1_ack, m1_q,
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, busy
  );

  // Environment view: requesting masters plus the register slaves.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
`ifdef FX_BUS_ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    output fx_q,
    input  m0_ack, m0_q, m1_ack, m1_q,
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr, busy
  );
endinterface

// File: rtl/fx_bus_arb_rr.sv
// Combinational two-way round-robin picker for the fx bus arbiter.
// With FX_BUS_ARB_LOCK_EN, an active lock restricts the grant to the last winner.
module fx_arb_rr (
  input  logic [1:0] req,
  input  logic       rr_last,
`ifdef FX_BUS_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
`ifdef FX_BUS_ARB_LOCK_EN
    if (lock) begin
      gnt_valid = req[rr_last];
      gnt_id    = rr_last;
    end else
`endif
    if (req == 2'b11) begin
      gnt_valid = 1'b1;
      gnt_id    = ~rr_last;
    end else if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (req[1]) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end
endmodule

// File: rtl/fx_bus_arb.sv
// Two-master arbiter/sequencer for the fx register bus: one single-byte op at a time, fair alternation.
// FX_BUS_ARB_LOCK_EN adds m0_lock/m1_lock for atomic multi-byte sequences.
module fx_bus_arb
  import fx_bus_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  fx_bus_arb_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              rr_last_q, rr_last_d;
  logic              fx_wr_q, fx_wr_d;
  logic              fx_rd_q, fx_rd_d;
  logic [ADDR_W-1:0] fx_waddr_q, fx_waddr_d;
  logic [ADDR_W-1:0] fx_raddr_q, fx_raddr_d;
  logic [DATA_W-1:0] fx_data_q, fx_data_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_q_q, m0_q_d;
  logic [DATA_W-1:0] m1_q_q, m1_q_d;
  logic              busy_q, busy_d;

  logic [1:0]        req;
  logic              gnt_valid;
  logic              gnt_id;
  logic              lock_eff;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req       = {bus.m1_req, bus.m0_req};
  assign sel_we    = gnt_id ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = gnt_id ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = gnt_id ? bus.m1_wdata : bus.m0_wdata;

`ifdef FX_BUS_ARB_LOCK_EN
  logic lock_q, lock_d;
  // The lock only holds while the owner (always rr_last) keeps its lock input high.
  assign lock_eff = lock_q & (rr_last_q ? bus.m1_lock : bus.m0_lock);
`else
  assign lock_eff = 1'b0;
`endif

  fx_arb_rr u_rr (
    .req       (req),
    .rr_last   (rr_last_q),
`ifdef FX_BUS_ARB_LOCK_EN
    .lock      (lock_eff),
`endif
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    rr_last_d  = rr_last_q;
    fx_wr_d    = 1'b0;
    fx_rd_d    = 1'b0;
    fx_waddr_d = fx_waddr_q;
    fx_raddr_d = fx_raddr_q;
    fx_data_d  = fx_data_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_q_d     = m0_q_q;
    m1_q_d     = m1_q_q;
`ifdef FX_BUS_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ISSUE;
          gnt_d   = gnt_id;
          we_d    = sel_we;
          if (!lock_eff) rr_last_d = gnt_id;
          // Strobe and address are registered here so they appear during ISSUE.
          fx_wr_d = sel_we;
          fx_rd_d = ~sel_we;
          if (sel_we) fx_waddr_d = sel_addr;
          else        fx_raddr_d = sel_addr;
          fx_data_d = sel_wdata;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d  = ACK;
          m0_ack_d = ~gnt_q;
          m1_ack_d = gnt_q;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        state_d = ACK;
        if (gnt_q) m1_q_d = bus.fx_q;
        else       m0_q_d = bus.fx_q;
        m0_ack_d = ~gnt_q;
        m1_ack_d = gnt_q;
      end
      ACK: begin
        state_d = IDLE;
`ifdef FX_BUS_ARB_LOCK_EN
        lock_d  = gnt_q ? bus.m1_lock : bus.m0_lock;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      rr_last_q  <= 1'b1;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      fx_data_q  <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_q_q     <= '0;
      m1_q_q     <= '0;
      busy_q     <= 1'b0;
`ifdef FX_BUS_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      rr_last_q  <= rr_last_d;
      fx_wr_q    <= fx_wr_d;
      fx_rd_q    <= fx_rd_d;
      fx_waddr_q <= fx_waddr_d;
      fx_raddr_q <= fx_raddr_d;
      fx_data_q  <= fx_data_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_q_q     <= m0_q_d;
      m1_q_q     <= m1_q_d;
      busy_q     <= busy_d;
`ifdef FX_BUS_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_q     = m0_q_q;
  assign bus.m1_q     = m1_q_q;
  assign bus.fx_wr    = fx_wr_q;
  assign bus.fx_rd    = fx_rd_q;
  assign bus.fx_waddr = fx_waddr_q;
  assign bus.fx_raddr = fx_raddr_q;
  assign bus.fx_data  = fx_data_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_fx_bus_arb.sv
// Bench for fx_bus_arb: directed scenarios plus random traffic against a transaction-level model.
// Lock scenario is compiled in with FX_BUS_ARB_LOCK_EN.
module tb_fx_bus_arb;
  logic clk_sys = 1'b0;
  logic rst_n   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  fx_bus_arb_if bus();
  fx_bus_arb dut (.clk_sys(clk_sys), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Slave memory: dev_id 0x01 mapped (64 bytes), everything else reads 0.
  logic [7:0]  mem [64];
  bit          rd_pend;
  logic [21:0] rd_addr;
  bit          prev_strobe;

  // Transaction-level model state.
  bit          tx_valid;
  int          tx_start, tx_ack, idle_from;
  bit          tx_g, tx_we;
  logic [21:0] tx_addr;
  logic [7:0]  tx_wdata, tx_rdata;
  bit          last;
  logic [7:0]  exp_q [2];
  bit          e_ack [2];
`ifdef FX_BUS_ARB_LOCK_EN
  bit          locked;
  bit          lock_owner;
`endif

  int ack_ids[$];
  int ack_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] slave_val(input logic [21:0] a);
    return (a[21:16] == 6'h01) ? mem[a[5:0]] : 8'h00;
  endfunction

  function automatic int outs_ones();
    return $countones({bus.m0_ack, bus.m1_ack, bus.m0_q, bus.m1_q, bus.fx_wr, bus.fx_waddr,
                       bus.fx_data, bus.fx_rd, bus.fx_raddr, bus.busy});
  endfunction

  task automatic model_reset();
    tx_valid  = 1'b0;
    idle_from = 0;
    last      = 1'b1;
    exp_q[0]  = 8'h00;
    exp_q[1]  = 8'h00;
`ifdef FX_BUS_ARB_LOCK_EN
    locked    = 1'b0;
`endif
  endtask

  // Decide what the arbiter does with the inputs present during cycle cyc.
  task automatic model_eval();
    bit [1:0] r;
    bit g;
    bit hold;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef FX_BUS_ARB_LOCK_EN
    if (tx_valid && cyc == tx_ack) begin
      locked     = tx_g ? bus.m1_lock : bus.m0_lock;
      lock_owner = tx_g;
    end
`endif
    if (cyc < idle_from) return;
    r    = {bus.m1_req, bus.m0_req};
    hold = 1'b0;
`ifdef FX_BUS_ARB_LOCK_EN
    if (locked && (lock_owner ? bus.m1_lock : bus.m0_lock)) begin
      hold = 1'b1;
      r[!lock_owner] = 1'b0;
    end
`endif
    if (r == 2'b00) return;
    g = (r == 2'b11) ? !last : r[1];
    if (!hold) last = g;
    tx_valid  = 1'b1;
    tx_start  = cyc;
    tx_g      = g;
    tx_we     = g ? bus.m1_we    : bus.m0_we;
    tx_addr   = g ? bus.m1_addr  : bus.m0_addr;
    tx_wdata  = g ? bus.m1_wdata : bus.m0_wdata;
    tx_ack    = cyc + (tx_we ? 2 : 3);
    idle_from = tx_ack + 1;
    tx_rdata  = slave_val(tx_addr);
  endtask

  task automatic check_cycle();
    bit in_tx, e_wr, e_rd, strobe;
    in_tx    = tx_valid && cyc > tx_start && cyc <= tx_ack;
    e_wr     = tx_valid && cyc == tx_start + 1 && tx_we;
    e_rd     = tx_valid && cyc == tx_start + 1 && !tx_we;
    e_ack[0] = tx_valid && cyc == tx_ack && !tx_g;
    e_ack[1] = tx_valid && cyc == tx_ack && tx_g;
    if (tx_valid && cyc == tx_ack) begin
      if (!tx_we) exp_q[tx_g] = tx_rdata;
      $display("txn m%0d %s addr=0x%06h data=0x%02h cyc=%0d", tx_g, tx_we ? "wr" : "rd",
               tx_addr, tx_we ? tx_wdata : tx_rdata, cyc);
    end
    check_eq("busy",  bus.busy,   in_tx);
    check_eq("fx_wr", bus.fx_wr,  e_wr);
    check_eq("fx_rd", bus.fx_rd,  e_rd);
    check_eq("ack0",  bus.m0_ack, e_ack[0]);
    check_eq("ack1",  bus.m1_ack, e_ack[1]);
    check_eq("q0",    bus.m0_q,   exp_q[0]);
    check_eq("q1",    bus.m1_q,   exp_q[1]);
    if (e_wr) begin
      check_eq("waddr", bus.fx_waddr, tx_addr);
      check_eq("wdata", bus.fx_data,  tx_wdata);
    end
    if (e_rd) check_eq("raddr", bus.fx_raddr, tx_addr);
    strobe = bus.fx_wr | bus.fx_rd;
    check_eq("strobe_excl", bus.fx_wr & bus.fx_rd, 0);
    check_eq("strobe_adj",  strobe & prev_strobe,  0);
    prev_strobe = strobe;
  endtask

  // One clock: model consumes current inputs, then outputs are checked and the slave responds.
  task automatic step();
    model_eval();
    @(posedge clk_sys);
    #1;
    cyc++;
    check_cycle();
    bus.fx_q = rd_pend ? slave_val(rd_addr) : 8'h00;
    rd_pend  = bus.fx_rd;
    rd_addr  = bus.fx_raddr;
    if (bus.fx_wr && bus.fx_waddr[21:16] == 6'h01) mem[bus.fx_waddr[5:0]] = bus.fx_data;
  endtask

  task automatic set_op(input int g, input bit req, input bit we, input logic [21:0] a, input logic [7:0] d);
    if (g == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic set_req(input int g, input bit req);
    if (g == 0) bus.m0_req = req;
    else        bus.m1_req = req;
  endtask

  task automatic rand_op(input int g);
    logic [21:0] a;
    logic [5:0]  off;
    logic [7:0]  d;
    off = 6'($urandom_range(63, 0));
    d   = 8'($urandom);
    a   = {(($urandom_range(3, 0) == 0) ? 6'h3F : 6'h01), 10'd0, off};
    set_op(g, 1'b1, $urandom_range(1, 0) == 1, a, d);
  endtask

  task automatic wait_ack(input int g, input int bound, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!e_ack[g] && n < bound);
    check_eq(tag, (g == 0) ? bus.m0_ack : bus.m1_ack, 1);
  endtask

  task automatic do_op(input int g, input bit we, input logic [21:0] a, input logic [7:0] d, input string tag);
    set_op(g, 1'b1, we, a, d);
    wait_ack(g, 12, tag);
    set_req(g, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_outs", outs_ones(), 0);
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    set_op(0, 1'b0, 1'b0, 22'h0, 8'h0);
    set_op(1, 1'b0, 1'b0, 22'h0, 8'h0);
`ifdef FX_BUS_ARB_LOCK_EN
    bus.m0_lock = 1'b0;
    bus.m1_lock = 1'b0;
`endif
    bus.fx_q = 8'h00;
    model_reset();
    #2;
    do_reset(3);

    // m0 write, m1 idle.
    do_op(0, 1'b1, 22'h010020, 8'h5A, "t1_ack");
    check_eq("t1_mem", mem[6'h20], 8'h5A);

    // m1 read of a preloaded byte; m0_q must stay put.
    mem[6'h11] = 8'hA5;
    do_op(1, 1'b0, 22'h010051, 8'h00, "t2_ack");
    check_eq("t2_q1", bus.m1_q, 8'hA5);
    check_eq("t2_q0", bus.m0_q, 8'h00);
    step();

    // Both masters hold read requests after reset: m0, m1, m0, m1, acks 4 cycles apart.
    do_reset(2);
    set_op(0, 1'b1, 1'b0, 22'h010011, 8'h00);
    set_op(1, 1'b1, 1'b0, 22'h010020, 8'h00);
    repeat (16) begin
      step();
      if (bus.m0_ack) begin ack_ids.push_back(0); ack_cyc.push_back(cyc); end
      if (bus.m1_ack) begin ack_ids.push_back(1); ack_cyc.push_back(cyc); end
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    check_eq("t3_nacks", ack_ids.size(), 4);
    for (int i = 0; i < ack_ids.size() && i < 4; i++) begin
      check_eq("t3_order", ack_ids[i], i % 2);
      if (i > 0) check_eq("t3_gap", ack_cyc[i] - ack_cyc[i-1], 4);
    end
    step();

    // Reset during the CAPT cycle of an m0 read, then an m1 write.
    set_op(0, 1'b1, 1'b0, 22'h010011, 8'h00);
    step();
    step();
    check_eq("t4_capt_busy", bus.busy, 1);
    set_req(0, 1'b0);
    do_reset(2);
    do_op(1, 1'b1, 22'h010030, 8'h3C, "t4_ack");
    check_eq("t4_mem", mem[6'h30], 8'h3C);

    // Mapped read to make m0_q non-zero, then an unmapped read that must return 0.
    mem[6'h05] = 8'h77;
    do_op(0, 1'b0, 22'h010005, 8'h00, "t5a_ack");
    check_eq("t5a_q0", bus.m0_q, 8'h77);
    do_op(0, 1'b0, 22'h3F0000, 8'h00, "t5_ack");
    check_eq("t5_q0", bus.m0_q, 8'h00);

`ifdef FX_BUS_ARB_LOCK_EN
    // m1 locked burst of four writes while m0 keeps requesting.
    set_op(1, 1'b1, 1'b1, 22'h010024, 8'h11);
    bus.m1_lock = 1'b1;
    step();
    set_op(0, 1'b1, 1'b0, 22'h010005, 8'h00);
    for (int i = 0; i < 4; i++) begin
      wait_ack(1, 12, "lk_m1_ack");
      bus.m1_lock = (i < 3);
      if (i < 3) set_op(1, 1'b1, 1'b1, 22'h010025 + 22'(i), 8'h12 + 8'(i));
      else       set_req(1, 1'b0);
    end
    wait_ack(0, 12, "lk_m0_ack");
    set_req(0, 1'b0);
    for (int i = 0; i < 4; i++) check_eq("lk_mem", mem[6'h24 + 6'(i)], 8'h11 + 8'(i));
`endif

    // Random traffic: masters raise requests at will and may chain ops on their ack.
    for (int k = 0; k < 800; k++) begin
      step();
      for (int g = 0; g < 2; g++) begin
        bit rq;
        rq = (g == 0) ? bus.m0_req : bus.m1_req;
        if (rq && e_ack[g]) begin
          if ($urandom_range(1, 0) == 1) rand_op(g);
          else set_req(g, 1'b0);
        end else if (!rq && $urandom_range(3, 0) == 0) begin
          rand_op(g);
        end
      end
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
